// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory bus between instruction fetch and
// data access. Data has priority, but every data access is followed by a fetch.
module mem_arbiter #(
    parameter int                ADDR_W   = 18,
    parameter int                DATA_W   = 16,
    parameter int                WAIT_CYC = 1,
    parameter logic [DATA_W-1:0] NOP_INST = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_data_o,
    output logic              inst_valid_o,
    input  logic              mem_re_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic              stall_o,
    output logic              bus_en_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    localparam int               CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dreq;
    logic             acc_last;
    logic             grant_ok;
    logic             inst_fin;
    logic             data_fin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A finished data access hands the bus to a waiting fetch before anything else.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (grant_ok) begin
            cnt_nxt = '0;
            if ((state == DATA) && inst_req_i) begin
                state_nxt = INST;
            end else if (dreq) begin
                state_nxt = DATA;
            end else if (inst_req_i) begin
                state_nxt = INST;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // re and we together is an illegal request and is ignored entirely.
    always_comb begin
        dreq     = mem_re_i ^ mem_we_i;
        acc_last = (state != IDLE) && (cnt == CNT_LAST);
        grant_ok = (state == IDLE) || acc_last;
        inst_fin = acc_last && (state == INST);
        data_fin = acc_last && (state == DATA);
        stall_o  = dreq & ~mem_done_o;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_en_o     <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            inst_data_o  <= NOP_INST;
            mem_rdata_o  <= '0;
            inst_valid_o <= 1'b0;
            mem_done_o   <= 1'b0;
        end else begin
            inst_valid_o <= inst_fin;
            mem_done_o   <= data_fin;
            if (inst_fin) begin
                inst_data_o <= bus_rdata_i;
            end
            if (data_fin && !bus_we_o) begin
                mem_rdata_o <= bus_rdata_i;
            end
            // Address and write data are frozen here for the whole access.
            if (grant_ok) begin
                bus_en_o <= (state_nxt != IDLE);
                bus_we_o <= (state_nxt == DATA) && mem_we_i;
                if (state_nxt == DATA) begin
                    bus_addr_o  <= mem_addr_i;
                    bus_wdata_o <= mem_wdata_i;
                end else if (state_nxt == INST) begin
                    bus_addr_o <= inst_addr_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model, on WAIT_CYC=1 and WAIT_CYC=3 instances.
module tb_mem_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic          mem_re = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] bus_rdata = '0;

    logic [DW-1:0] inst_data [2];
    logic          inst_valid[2];
    logic [DW-1:0] mem_rdata [2];
    logic          mem_done  [2];
    logic          stall     [2];
    logic          bus_en    [2];
    logic          bus_we    [2];
    logic [AW-1:0] bus_addr  [2];
    logic [DW-1:0] bus_wdata [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1), .NOP_INST(16'h0800)) u_w1 (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr),
        .inst_data_o(inst_data[0]), .inst_valid_o(inst_valid[0]),
        .mem_re_i(mem_re), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata[0]), .mem_done_o(mem_done[0]), .stall_o(stall[0]),
        .bus_en_o(bus_en[0]), .bus_we_o(bus_we[0]), .bus_addr_o(bus_addr[0]),
        .bus_wdata_o(bus_wdata[0]), .bus_rdata_i(bus_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(3), .NOP_INST(16'h0800)) u_w3 (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr),
        .inst_data_o(inst_data[1]), .inst_valid_o(inst_valid[1]),
        .mem_re_i(mem_re), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata[1]), .mem_done_o(mem_done[1]), .stall_o(stall[1]),
        .bus_en_o(bus_en[1]), .bus_we_o(bus_we[1]), .bus_addr_o(bus_addr[1]),
        .bus_wdata_o(bus_wdata[1]), .bus_rdata_i(bus_rdata)
    );

    // Transaction-level model: the access on the bus and the cycles it has left.
    typedef struct packed {
        logic [1:0]    kind;   // 0 none, 1 fetch, 2 data
        logic [2:0]    rem;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] inst;
        logic [DW-1:0] rdata;
        logic          ivld;
        logic          done;
    } mdl_t;

    mdl_t mdl[2];

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m       = '0;
        m.inst  = 16'h0800;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int w, logic ireq, logic dq, logic we,
                                      logic [AW-1:0] ia, logic [AW-1:0] ma,
                                      logic [DW-1:0] wd, logic [DW-1:0] rd);
        mdl_t n;
        logic fin;
        n      = m;
        fin    = (m.kind != 2'd0) && (m.rem == 3'd1);
        n.ivld = fin && (m.kind == 2'd1);
        n.done = fin && (m.kind == 2'd2);
        if (n.ivld) n.inst = rd;
        if (n.done && !m.we) n.rdata = rd;
        if ((m.kind == 2'd0) || fin) begin
            if (fin && (m.kind == 2'd2) && ireq) n.kind = 2'd1;
            else if (dq)                         n.kind = 2'd2;
            else if (ireq)                       n.kind = 2'd1;
            else                                 n.kind = 2'd0;
            n.rem = 3'(w);
            n.we  = 1'b0;
            if (n.kind == 2'd2) begin
                n.addr  = ma;
                n.we    = we;
                n.wdata = wd;
            end else if (n.kind == 2'd1) begin
                n.addr = ia;
            end
        end else begin
            n.rem = m.rem - 3'd1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) mdl[k] <= mdl_reset();
            else      mdl[k] <= mdl_next(mdl[k], (k == 0) ? 1 : 3, inst_req, mem_re ^ mem_we,
                                         mem_we, inst_addr, mem_addr, mem_wdata, bus_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        inst_req = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({bus_en[k], bus_we[k], inst_valid[k], mem_done[k], stall[k], inst_data[k], mem_rdata[k], bus_addr[k], bus_wdata[k]}
                !== {5'b0, 16'h0800, 16'h0, 18'h0, 16'h0})
                $display("FAIL reset_state[%0d]: got en=%b we=%b iv=%b dn=%b st=%b inst=%h rd=%h a=%h wd=%h want zeros, inst=0800",
                         k, bus_en[k], bus_we[k], inst_valid[k], mem_done[k], stall[k], inst_data[k], mem_rdata[k], bus_addr[k], bus_wdata[k]);
            else n_pass++;
        end
        rst = 1'b1;
        tick();
        inst_req  = 1'b1;
        inst_addr = 18'h00123;
        tick();
        n_total++;
        if (bus_en[1] !== 1'b1) $display("FAIL reset_pre_access: bus_en got %b want 1", bus_en[1]);
        else n_pass++;
        inst_req  = 1'b0;
        bus_rdata = 16'hBEEF;
        tick();
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({bus_en[1], stall[1], inst_data[1], inst_data[0], inst_valid[0]} !== {2'b00, 16'h0800, 16'h0800, 1'b0})
            $display("FAIL reset_mid_access: got en=%b st=%b inst3=%h inst1=%h iv=%b want en=0 st=0 inst=0800 iv=0",
                     bus_en[1], stall[1], inst_data[1], inst_data[0], inst_valid[0]);
        else n_pass++;
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if ({bus_en[0], bus_en[1]} !== 2'b00) $display("FAIL reset_idle: cycle %0d bus_en got %b%b want 00", i, bus_en[0], bus_en[1]);
            else n_pass++;
        end
    endtask

    task automatic test_fetch();
        inst_req  = 1'b1;
        inst_addr = 18'h00010;
        bus_rdata = 16'h6801;
        tick();
        n_total++;
        if ({bus_en[0], bus_we[0], bus_addr[0], inst_valid[0]} !== {1'b1, 1'b0, 18'h00010, 1'b0})
            $display("FAIL fetch_grant: got en=%b we=%b a=%h iv=%b want 1 0 00010 0", bus_en[0], bus_we[0], bus_addr[0], inst_valid[0]);
        else n_pass++;
        inst_req = 1'b0;
        tick();
        n_total++;
        if ({inst_valid[0], inst_data[0], bus_en[0]} !== {1'b1, 16'h6801, 1'b0})
            $display("FAIL fetch_done: got iv=%b inst=%h en=%b want 1 6801 0", inst_valid[0], inst_data[0], bus_en[0]);
        else n_pass++;
        tick();
        n_total++;
        if ({inst_valid[0], inst_data[0]} !== {1'b0, 16'h6801})
            $display("FAIL fetch_hold: got iv=%b inst=%h want 0 6801", inst_valid[0], inst_data[0]);
        else n_pass++;
        drain();
    endtask

    task automatic test_priority();
        inst_req  = 1'b1;
        inst_addr = 18'h00020;
        mem_re    = 1'b1;
        mem_addr  = 18'h0BF01;
        bus_rdata = 16'h0041;
        #1;
        n_total++;
        if (stall[0] !== 1'b1) $display("FAIL prio_stall_req: got %b want 1", stall[0]);
        else n_pass++;
        tick();
        n_total++;
        if ({bus_en[0], bus_we[0], bus_addr[0], stall[0], inst_valid[0], mem_done[0]} !== {1'b1, 1'b0, 18'h0BF01, 1'b1, 2'b00})
            $display("FAIL prio_data_first: got en=%b we=%b a=%h st=%b iv=%b dn=%b want 1 0 0bf01 1 0 0",
                     bus_en[0], bus_we[0], bus_addr[0], stall[0], inst_valid[0], mem_done[0]);
        else n_pass++;
        tick();
        n_total++;
        if ({mem_done[0], mem_rdata[0], inst_data[0], stall[0], bus_en[0], bus_we[0], bus_addr[0]}
            !== {1'b1, 16'h0041, 16'h6801, 1'b0, 1'b1, 1'b0, 18'h00020})
            $display("FAIL prio_done_then_inst: got dn=%b rd=%h inst=%h st=%b en=%b we=%b a=%h want 1 0041 6801 0 1 0 00020",
                     mem_done[0], mem_rdata[0], inst_data[0], stall[0], bus_en[0], bus_we[0], bus_addr[0]);
        else n_pass++;
        mem_re    = 1'b0;
        inst_req  = 1'b0;
        bus_rdata = 16'h1234;
        tick();
        n_total++;
        if ({inst_valid[0], inst_data[0], mem_done[0], bus_en[0]} !== {1'b1, 16'h1234, 1'b0, 1'b0})
            $display("FAIL prio_inst_after: got iv=%b inst=%h dn=%b en=%b want 1 1234 0 0", inst_valid[0], inst_data[0], mem_done[0], bus_en[0]);
        else n_pass++;
        drain();
    endtask

    task automatic test_write();
        inst_req  = 1'b1;
        inst_addr = 18'h00030;
        mem_we    = 1'b1;
        mem_addr  = 18'h00200;
        mem_wdata = 16'h00AA;
        bus_rdata = 16'h5555;
        tick();
        n_total++;
        if ({bus_en[0], bus_we[0], bus_addr[0], bus_wdata[0], stall[0]} !== {1'b1, 1'b1, 18'h00200, 16'h00AA, 1'b1})
            $display("FAIL write_bus: got en=%b we=%b a=%h wd=%h st=%b want 1 1 00200 00aa 1",
                     bus_en[0], bus_we[0], bus_addr[0], bus_wdata[0], stall[0]);
        else n_pass++;
        tick();
        n_total++;
        if ({mem_done[0], mem_rdata[0], bus_en[0], bus_we[0], bus_addr[0]} !== {1'b1, 16'h0041, 1'b1, 1'b0, 18'h00030})
            $display("FAIL write_done: got dn=%b rd=%h en=%b we=%b a=%h want 1 0041 1 0 00030",
                     mem_done[0], mem_rdata[0], bus_en[0], bus_we[0], bus_addr[0]);
        else n_pass++;
        mem_we   = 1'b0;
        inst_req = 1'b0;
        tick();
        n_total++;
        if ({inst_valid[0], inst_data[0], mem_done[0]} !== {1'b1, 16'h5555, 1'b0})
            $display("FAIL write_fetch: got iv=%b inst=%h dn=%b want 1 5555 0", inst_valid[0], inst_data[0], mem_done[0]);
        else n_pass++;
        drain();
    endtask

    task automatic test_wait3();
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        int            prev;
        inst_req  = 1'b1;
        mem_re    = 1'b1;
        inst_addr = 18'h00040;
        mem_addr  = 18'h00050;
        tick();
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 3; c++) begin
                exp_a = (j % 2 == 0) ? 18'h00050 : 18'h00040;
                prev  = j - 1;
                n_total++;
                if ({bus_en[1], bus_we[1], bus_addr[1]} !== {1'b1, 1'b0, exp_a})
                    $display("FAIL w3_bus acc %0d cyc %0d: got en=%b we=%b a=%h want 1 0 %h", j, c, bus_en[1], bus_we[1], bus_addr[1], exp_a);
                else n_pass++;
                if (c == 0 && j > 0) begin
                    exp_d = DW'(16'hA000 + prev);
                    n_total++;
                    if (prev % 2 == 0) begin
                        if ({inst_valid[1], mem_done[1], mem_rdata[1], stall[1]} !== {2'b01, exp_d, 1'b0})
                            $display("FAIL w3_data_pulse acc %0d: got iv=%b dn=%b rd=%h st=%b want 0 1 %h 0",
                                     prev, inst_valid[1], mem_done[1], mem_rdata[1], stall[1], exp_d);
                        else n_pass++;
                    end else begin
                        if ({inst_valid[1], mem_done[1], inst_data[1], stall[1]} !== {2'b10, exp_d, 1'b1})
                            $display("FAIL w3_inst_pulse acc %0d: got iv=%b dn=%b inst=%h st=%b want 1 0 %h 1",
                                     prev, inst_valid[1], mem_done[1], inst_data[1], stall[1], exp_d);
                        else n_pass++;
                    end
                end else begin
                    n_total++;
                    if ({inst_valid[1], mem_done[1], stall[1]} !== 3'b001)
                        $display("FAIL w3_no_pulse acc %0d cyc %0d: got iv=%b dn=%b st=%b want 0 0 1", j, c, inst_valid[1], mem_done[1], stall[1]);
                    else n_pass++;
                end
                bus_rdata = DW'(16'hA000 + j);
                if (c == 2) begin
                    inst_addr = 18'h00040;
                    mem_addr  = 18'h00050;
                end else begin
                    inst_addr = '1;
                    mem_addr  = '1;
                end
                tick();
            end
        end
        n_total++;
        if ({inst_valid[1], mem_done[1], inst_data[1]} !== {2'b10, 16'hA003})
            $display("FAIL w3_last_pulse: got iv=%b dn=%b inst=%h want 1 0 a003", inst_valid[1], mem_done[1], inst_data[1]);
        else n_pass++;
        drain();
    endtask

    task automatic test_illegal();
        int fetches;
        fetches   = 0;
        inst_req  = 1'b1;
        inst_addr = 18'h00060;
        mem_re    = 1'b1;
        mem_we    = 1'b1;
        #1;
        n_total++;
        if (stall[0] !== 1'b0) $display("FAIL illegal_stall_now: got %b want 0", stall[0]);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (inst_valid[0] === 1'b1) fetches++;
            n_total++;
            if ({stall[0], mem_done[0], bus_we[0]} !== 3'b000 || (bus_en[0] === 1'b1 && bus_addr[0] !== 18'h00060))
                $display("FAIL illegal_cycle %0d: got st=%b dn=%b we=%b en=%b a=%h want st=0 dn=0 we=0 a=00060",
                         i, stall[0], mem_done[0], bus_we[0], bus_en[0], bus_addr[0]);
            else n_pass++;
        end
        n_total++;
        if (fetches < 3) $display("FAIL illegal_fetches: got %0d want >= 3", fetches);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        logic [4:0] got_f;
        logic [4:0] exp_f;
        rst = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 800; i++) begin
            inst_req  = 1'($urandom_range(0, 1));
            mem_re    = ($urandom_range(0, 2) == 0);
            mem_we    = ($urandom_range(0, 3) == 0);
            inst_addr = AW'($urandom);
            mem_addr  = AW'($urandom);
            mem_wdata = DW'($urandom);
            bus_rdata = DW'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                got_f = {bus_en[k], bus_we[k], inst_valid[k], mem_done[k], stall[k]};
                exp_f = {mdl[k].kind != 2'd0, mdl[k].we, mdl[k].ivld, mdl[k].done, (mem_re ^ mem_we) & ~mdl[k].done};
                n_total++;
                if (got_f !== exp_f) $display("FAIL rand_ctrl[%0d] cyc %0d: got en/we/iv/dn/st=%b want %b", k, i, got_f, exp_f);
                else n_pass++;
                n_total++;
                if ({inst_data[k], mem_rdata[k]} !== {mdl[k].inst, mdl[k].rdata})
                    $display("FAIL rand_data[%0d] cyc %0d: got inst=%h rd=%h want inst=%h rd=%h",
                             k, i, inst_data[k], mem_rdata[k], mdl[k].inst, mdl[k].rdata);
                else n_pass++;
                if (mdl[k].kind != 2'd0) begin
                    n_total++;
                    if (bus_addr[k] !== mdl[k].addr) $display("FAIL rand_addr[%0d] cyc %0d: got %h want %h", k, i, bus_addr[k], mdl[k].addr);
                    else n_pass++;
                end
                if (mdl[k].we) begin
                    n_total++;
                    if (bus_wdata[k] !== mdl[k].wdata) $display("FAIL rand_wdata[%0d] cyc %0d: got %h want %h", k, i, bus_wdata[k], mdl[k].wdata);
                    else n_pass++;
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_wait3();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
